arm_alu: RTL and testbench

- 32-bit ALU for the single-cycle ARM datapath.
- Computes ADD, SUB, AND and ORR on SrcA/SrcB and produces combinational NZCV flags.
- Holds the architectural NZCV flags in two enabled registers: N/Z in one, C/V in the other.
- Evaluates the instruction condition field against the stored flags; the result (cond_ex) gates register, memory and PC writes elsewhere in the datapath.

---
 rtl/arm_alu.sv | 96 +++++++++
 tb/tb_arm_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_alu.sv
// arm_alu: 32-bit ADD/SUB/AND/ORR ALU with NZCV flags,
// stored flag registers and condition-field evaluation.
module arm_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       alu_control,
  input  logic [1:0]       flag_w,
  input  logic [3:0]       cond,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags,
  output logic [3:0]       flags,
  output logic             cond_ex
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;
  logic             w_n;
  logic             w_z;
  logic             w_c;
  logic             w_v;
  logic [1:0]       r_nz;
  logic [1:0]       r_cv;
  logic             w_fn;
  logic             w_fz;
  logic             w_fc;
  logic             w_fv;

  // SUB reuses the adder with inverted B and carry-in of 1
  assign w_b_eff = alu_control[0] ? ~src_b : src_b;
  assign w_sum   = {1'b0, src_a} + {1'b0, w_b_eff}
                 + {{WIDTH{1'b0}}, alu_control[0]};
  assign w_arith = ~alu_control[1];

  always_comb begin
    alu_result = '0;
    case (alu_control)
      2'b00:   alu_result = w_sum[WIDTH-1:0];
      2'b01:   alu_result = w_sum[WIDTH-1:0];
      2'b10:   alu_result = src_a & src_b;
      default: alu_result = src_a | src_b;
    endcase
  end

  assign w_n = alu_result[WIDTH-1];
  assign w_z = (alu_result == '0);
  assign w_c = w_arith & w_sum[WIDTH];
  assign w_v = w_arith
             & (src_a[WIDTH-1] == w_b_eff[WIDTH-1])
             & (w_sum[WIDTH-1] != src_a[WIDTH-1]);

  assign alu_flags = {w_n, w_z, w_c, w_v};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (flag_w[1] & cond_ex) r_nz <= alu_flags[3:2];
      if (flag_w[0] & cond_ex) r_cv <= alu_flags[1:0];
    end
  end

  assign flags = {r_nz, r_cv};
  assign w_fn  = r_nz[1];
  assign w_fz  = r_nz[0];
  assign w_fc  = r_cv[1];
  assign w_fv  = r_cv[0];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = w_fz;
      4'b0001: cond_ex = ~w_fz;
      4'b0010: cond_ex = w_fc;
      4'b0011: cond_ex = ~w_fc;
      4'b0100: cond_ex = w_fn;
      4'b0101: cond_ex = ~w_fn;
      4'b0110: cond_ex = w_fv;
      4'b0111: cond_ex = ~w_fv;
      4'b1000: cond_ex = w_fc & ~w_fz;
      4'b1001: cond_ex = ~(w_fc & ~w_fz);
      4'b1010: cond_ex = (w_fn == w_fv);
      4'b1011: cond_ex = (w_fn != w_fv);
      4'b1100: cond_ex = ~w_fz & (w_fn == w_fv);
      4'b1101: cond_ex = ~(~w_fz & (w_fn == w_fv));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_arm_alu.sv
// tb_arm_alu: directed scoreboard bench for arm_alu.
// Expected values are queued with stimulus and checked after settle.
module tb_arm_alu;

  logic        clk;
  logic        reset;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  alu_control;
  logic [1:0]  flag_w;
  logic [3:0]  cond;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        cond_ex;

  arm_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_control(alu_control),
    .flag_w     (flag_w),
    .cond       (cond),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .flags      (flags),
    .cond_ex    (cond_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_RES = 0;
  localparam int S_AF  = 1;
  localparam int S_FL  = 2;
  localparam int S_CE  = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } item_t;

  item_t q[$];
  int    n_run;
  int    n_fail;

  task automatic exp_v(input string tag, input int sel,
                       input logic [31:0] val);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.val = val;
    q.push_back(it);
  endtask

  task automatic check_q();
    item_t       it;
    logic [31:0] obs;
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.sel)
        S_RES:   obs = alu_result;
        S_AF:    obs = {28'b0, alu_flags};
        S_FL:    obs = {28'b0, flags};
        default: obs = {31'b0, cond_ex};
      endcase
      n_run++;
      assert (obs === it.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h",
               it.tag, obs, it.val);
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] ctl, input logic [1:0] fw,
                       input logic [3:0] c);
    src_a       = a;
    src_b       = b;
    alu_control = ctl;
    flag_w      = fw;
    cond        = c;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(32'd2, 32'd5, 2'b00, 2'b00, 4'b1110);
    #1;
    exp_v("reset_flags", S_FL, 32'h0);
    exp_v("add_2_5_res", S_RES, 32'd7);
    exp_v("add_2_5_af", S_AF, 32'h0);
    exp_v("add_2_5_ce_al", S_CE, 32'h1);
    check_q();
    @(negedge clk);
    reset = 1'b0;

    // SUB 5-5 sets Z and C
    @(negedge clk);
    drive(32'd5, 32'd5, 2'b01, 2'b11, 4'b1110);
    #1;
    exp_v("sub_5_5_res", S_RES, 32'h0);
    exp_v("sub_5_5_af", S_AF, 32'h6);
    check_q();
    edge_settle();
    exp_v("sub_5_5_flags", S_FL, 32'h6);
    check_q();
    drive(32'd5, 32'd5, 2'b01, 2'b00, 4'b0000);
    #1;
    exp_v("eq_after_sub", S_CE, 32'h1);
    check_q();
    cond = 4'b0001;
    #1;
    exp_v("ne_after_sub", S_CE, 32'h0);
    check_q();

    // signed overflow on ADD
    @(negedge clk);
    drive(32'h7FFFFFFF, 32'd1, 2'b00, 2'b11, 4'b1110);
    #1;
    exp_v("add_ovf_res", S_RES, 32'h80000000);
    exp_v("add_ovf_af", S_AF, 32'h9);
    check_q();
    edge_settle();
    drive(32'h7FFFFFFF, 32'd1, 2'b00, 2'b00, 4'b1011);
    #1;
    exp_v("ovf_flags", S_FL, 32'h9);
    exp_v("lt_after_ovf", S_CE, 32'h0);
    check_q();
    cond = 4'b1010;
    #1;
    exp_v("ge_after_ovf", S_CE, 32'h1);
    check_q();
    cond = 4'b1000;
    #1;
    exp_v("hi_after_ovf", S_CE, 32'h0);
    check_q();
    cond = 4'b1100;
    #1;
    exp_v("gt_after_ovf", S_CE, 32'h1);
    check_q();
    cond = 4'b1101;
    #1;
    exp_v("le_after_ovf", S_CE, 32'h0);
    check_q();
    cond = 4'b1111;
    #1;
    exp_v("cond_1111", S_CE, 32'h0);
    check_q();

    // borrow and unsigned wrap
    @(negedge clk);
    drive(32'd3, 32'd5, 2'b01, 2'b00, 4'b1110);
    #1;
    exp_v("sub_3_5_res", S_RES, 32'hFFFFFFFE);
    exp_v("sub_3_5_af", S_AF, 32'h8);
    check_q();
    drive(32'hFFFFFFFF, 32'd1, 2'b00, 2'b00, 4'b1110);
    #1;
    exp_v("add_wrap_res", S_RES, 32'h0);
    exp_v("add_wrap_af", S_AF, 32'h6);
    check_q();

    // logic ops; then partial write keeps C/V
    @(negedge clk);
    drive(32'd5, 32'd3, 2'b01, 2'b11, 4'b1110);
    edge_settle();
    exp_v("sub_5_3_flags", S_FL, 32'h2);
    check_q();
    drive(32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 2'b00, 4'b1110);
    #1;
    exp_v("and_res", S_RES, 32'h00F000F0);
    exp_v("and_af", S_AF, 32'h0);
    check_q();
    @(negedge clk);
    drive(32'h0, 32'h0, 2'b11, 2'b10, 4'b1110);
    #1;
    exp_v("orr_res", S_RES, 32'h0);
    exp_v("orr_af", S_AF, 32'h4);
    check_q();
    edge_settle();
    exp_v("nz_only_write", S_FL, 32'h6);
    check_q();

    // failed condition blocks the flag write
    @(negedge clk);
    drive(32'd2, 32'd5, 2'b00, 2'b11, 4'b0001);
    #1;
    exp_v("ne_with_z", S_CE, 32'h0);
    check_q();
    edge_settle();
    exp_v("cond_fail_hold", S_FL, 32'h6);
    check_q();

    // asynchronous reset between edges
    @(negedge clk);
    drive(32'h7FFFFFFF, 32'd1, 2'b00, 2'b11, 4'b1110);
    #2;
    reset = 1'b1;
    #1;
    exp_v("async_reset", S_FL, 32'h0);
    check_q();
    edge_settle();
    exp_v("reset_over_write", S_FL, 32'h0);
    check_q();
    @(negedge clk);
    reset = 1'b0;
    edge_settle();
    exp_v("first_after_reset", S_FL, 32'h9);
    check_q();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
